vga_window_mapper: RTL and testbench
====================================

Name: vga_window_mapper

Overview:
- Maps VGA driver pixel coordinates (posX/posY) onto a dual-port frame-buffer read address.
- Supports a movable, integer-scaled image window inside the visible raster.
- Selects between buffer data and a background colour, pipeline-aligned to the RAM read latency.
- Sits between the VGA driver and buffer_ram_dp; replaces the fixed top-left, unscaled, address-0-fill mapping.

Parameters:
- H_RES, 1024, visible horizontal pixels.
- V_RES, 768, visible lines; posY >= V_RES is vertical blanking.
- CAM_X, 256, source image width; power of two.
- CAM_Y, 256, source image height; power of two.
- SCALE, 1, replication shift; each source pixel is shown as (2^SCALE)x(2^SCALE).
- DW, 3, pixel width (RGB111).
- RAM_LAT, 1, buffer read latency in clk cycles; must be 1..4.
- BG_COLOR, 3'b000, colour outside the window.
- INIT_OFF_X, 0, window left edge after reset.
- OFF_Y, 0, fixed window top edge.
- STEP, 64, horizontal move per accepted button request.
- Derived: AW = log2(CAM_X) + log2(CAM_Y); WIN_W = CAM_X<<SCALE; WIN_H = CAM_Y<<SCALE; MAX_OFF_X = H_RES - WIN_W.

Ports:
- clk  in  1  pixel clock (same clock as the VGA driver and RAM read port)
- rst  in  1  synchronous, active-high reset
- posX  in  12  next-pixel X from the VGA driver
- posY  in  11  next-pixel Y from the VGA driver
- mem_data  in  DW  buffer_ram_dp data_out
- bntr  in  1  move-right button, asynchronous, active-high
- bntl  in  1  move-left button, asynchronous, active-high
- addr_out  out  AW  buffer read address
- pixel_out  out  DW  pixel to the VGA driver pixelIn
- in_window  out  1  registered in-window flag aligned with addr_out
- off_x  out  12  current window left edge

Behaviour:
- All state updates on the rising edge of clk. rst is synchronous active-high and overrides everything.
- Reset values:
  - addr_out=0, in_window=0, pixel_out=0.
  - Delay-line flags = 0.
  - off_x = INIT_OFF_X.
  - Pending flags and synchronizers = 0.
- Stage 1 (1 cycle):
  - lx = posX - off_x; ly = posY - OFF_Y.
  - win = (posX >= off_x) && (lx < WIN_W) && (posY >= OFF_Y) && (ly < WIN_H).
  - If win: addr_out <= {ly>>SCALE, lx>>SCALE}, row-major, Y in the upper bits. Otherwise addr_out <= 0.
  - in_window <= win.
- Delay line: in_window is delayed RAM_LAT cycles, giving win_d.
- Output stage: pixel_out <= win_d ? mem_data : BG_COLOR.
- Total latency from posX/posY sample to pixel_out is RAM_LAT+2 edges. The driver's pixel lead must match this; integration is responsible.
- Buttons:
  - Each button passes through a 2-flop synchronizer, then rising-edge detect.
  - A rising edge sets pend_r (bntr) or pend_l (bntl).
  - Multiple edges before application still give a single step.
  - No debounce; the one-step-per-frame rule bounds bounce effects.
- Offset update, only on cycles with posY >= V_RES (blanking):
  - pend_r only: off_x <= min(off_x+STEP, MAX_OFF_X).
  - pend_l only: off_x <= (off_x < STEP) ? 0 : off_x-STEP.
  - Both pending: off_x unchanged.
  - In all three cases both pending flags clear on that same cycle.
  - An edge detected on the application cycle is kept pending for the next frame.
- off_x never changes while posY < V_RES, so there is no tearing within a frame.
- Coordinates beyond H_RES/V_RES are treated as outside the window.
- Reset mid-frame: pipeline flushes to 0/BG_COLOR on the next edge; pending requests are lost.

Test Plan:
- Defaults, reset then posX=0,posY=0 -> next edge addr_out=0, in_window=1; pixel_out=mem_data 3 edges after sample.
- posX=3, posY=5 -> addr_out=(2<<8)|1=513. posX=511, posY=511 -> addr_out=65535.
- posX=512, posY=0 -> in_window=0, addr_out=0, pixel_out=3'b000 after 3 edges even when mem_data=3'b111.
- Pulse bntr (4 cycles high) while posY=100:
  - off_x stays 0 until posY=768, then becomes 64.
  - Afterwards posX=64, posY=0 -> addr_out=0, in_window=1; posX=63 -> in_window=0.
- Clamp:
  - 10 frames each with one bntr pulse -> off_x saturates at 512.
  - Then 10 bntl frames -> off_x reaches 0 and stays.
  - bntr and bntl pulsed in the same frame -> off_x unchanged, both pending flags cleared.
- Reset with rst=1 mid-window (off_x=128) -> next edge addr_out=0, pixel_out=0, in_window=0, off_x=0. RAM_LAT=2 build -> pixel_out latency is 4 edges.

Source files
------------

// File: rtl/vga_window_mapper.sv
// vga_window_mapper
//   Turns the VGA driver's next-pixel coordinates into a frame-buffer read
//   address for a movable, integer-scaled image window. Outside the window the
//   background colour is shown. The in-window flag is delayed to match the RAM
//   read latency, so pixel_out stays aligned with the buffer data.
//   The left/right buttons move the window horizontally. Position changes are
//   applied only during vertical blanking, so a frame never tears.
//
// Ports
//   clk       in   pixel clock, shared with the VGA driver and the RAM read port
//   rst       in   synchronous, active-high reset
//   posX      in   [11:0] next-pixel X
//   posY      in   [10:0] next-pixel Y (posY >= V_RES means vertical blanking)
//   mem_data  in   [DW-1:0] buffer RAM read data (RAM_LAT cycles after addr_out)
//   bntr      in   move-right button (asynchronous)
//   bntl      in   move-left button (asynchronous)
//   addr_out  out  [AW-1:0] buffer read address, {row, column}
//   pixel_out out  [DW-1:0] pixel to the VGA driver
//   in_window out  registered in-window flag, aligned with addr_out
//   off_x     out  [11:0] current window left edge
module vga_window_mapper #(
  parameter int              H_RES      = 1024,
  parameter int              V_RES      = 768,
  parameter int              CAM_X      = 256,
  parameter int              CAM_Y      = 256,
  parameter int              SCALE      = 1,
  parameter int              DW         = 3,
  parameter int              RAM_LAT    = 1,
  parameter logic [DW-1:0]   BG_COLOR   = '0,
  parameter int              INIT_OFF_X = 0,
  parameter int              OFF_Y      = 0,
  parameter int              STEP       = 64,
  localparam int             XW         = $clog2(CAM_X),
  localparam int             YW         = $clog2(CAM_Y),
  localparam int             AW         = XW + YW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [11:0]   posX,
  input  logic [10:0]   posY,
  input  logic [DW-1:0] mem_data,
  input  logic          bntr,
  input  logic          bntl,
  output logic [AW-1:0] addr_out,
  output logic [DW-1:0] pixel_out,
  output logic          in_window,
  output logic [11:0]   off_x
);

  localparam int WIN_W     = CAM_X << SCALE;
  localparam int WIN_H     = CAM_Y << SCALE;
  localparam int MAX_OFF_X = H_RES - WIN_W;

  localparam logic signed [12:0] WIN_W_S = 13'(WIN_W);
  localparam logic signed [11:0] WIN_H_S = 12'(WIN_H);

  // Pipeline and control state
  logic [AW-1:0]      addr_p1_q,   addr_p1_d;
  logic               win_p1_q,    win_p1_d;
  logic [RAM_LAT-1:0] win_dly_q,   win_dly_d;
  logic [DW-1:0]      pix_p2_q,    pix_p2_d;
  logic [11:0]        off_x_q,     off_x_d;
  logic [2:0]         sync_r_q,    sync_r_d;
  logic [2:0]         sync_l_q,    sync_l_d;
  logic               pend_r_q,    pend_r_d;
  logic               pend_l_q,    pend_l_d;

  // Combinational helpers
  logic signed [12:0] lx;
  logic signed [11:0] ly;
  logic [XW-1:0]      col_idx;
  logic [YW-1:0]      row_idx;
  logic               win_d;
  logic               rise_r, rise_l;
  logic               blank;
  logic [12:0]        off_sum;

  // Stage 1: window test and address generation from the current coordinates
  always_comb begin
    lx       = signed'({1'b0, posX}) - signed'({1'b0, off_x_q});
    ly       = signed'({1'b0, posY}) - 12'(OFF_Y);
    col_idx  = XW'(lx[11:0] >> SCALE);
    row_idx  = YW'(ly[10:0] >> SCALE);
    // The raster bounds are tested too, so out-of-range coordinates never map.
    win_p1_d = (lx >= 0) && (lx < WIN_W_S) && (ly >= 0) && (ly < WIN_H_S) &&
               (posX < 12'(H_RES)) && (posY < 11'(V_RES));
    addr_p1_d = win_p1_d ? {row_idx, col_idx} : '0;
  end

  // RAM latency: in-window flag travels alongside the outstanding read
  always_comb begin
    win_dly_d = (win_dly_q << 1) | RAM_LAT'(win_p1_q);
    win_d     = win_dly_q[RAM_LAT-1];
  end

  // Stage 2: choose buffer data or background
  always_comb begin
    pix_p2_d = win_d ? mem_data : BG_COLOR;
  end

  // Button handling and offset update
  always_comb begin
    // [0],[1] form the synchronizer; [2] holds the previous synchronized level.
    sync_r_d = {sync_r_q[1:0], bntr};
    sync_l_d = {sync_l_q[1:0], bntl};
    rise_r   = sync_r_q[1] & ~sync_r_q[2];
    rise_l   = sync_l_q[1] & ~sync_l_q[2];
    blank    = (posY >= 11'(V_RES));
    off_sum  = {1'b0, off_x_q} + 13'(STEP);

    off_x_d  = off_x_q;
    pend_r_d = pend_r_q | rise_r;
    pend_l_d = pend_l_q | rise_l;

    if (blank) begin
      case ({pend_r_q, pend_l_q})
        2'b10:   off_x_d = (off_sum > 13'(MAX_OFF_X)) ? 12'(MAX_OFF_X) : off_sum[11:0];
        2'b01:   off_x_d = (off_x_q < 12'(STEP)) ? 12'd0 : off_x_q - 12'(STEP);
        default: off_x_d = off_x_q;
      endcase
      // Requests are consumed here; an edge arriving this very cycle waits
      // for the next blanking period.
      pend_r_d = rise_r;
      pend_l_d = rise_l;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_p1_q <= '0;
      win_p1_q  <= 1'b0;
      win_dly_q <= '0;
      pix_p2_q  <= '0;
      off_x_q   <= 12'(INIT_OFF_X);
      sync_r_q  <= '0;
      sync_l_q  <= '0;
      pend_r_q  <= 1'b0;
      pend_l_q  <= 1'b0;
    end else begin
      addr_p1_q <= addr_p1_d;
      win_p1_q  <= win_p1_d;
      win_dly_q <= win_dly_d;
      pix_p2_q  <= pix_p2_d;
      off_x_q   <= off_x_d;
      sync_r_q  <= sync_r_d;
      sync_l_q  <= sync_l_d;
      pend_r_q  <= pend_r_d;
      pend_l_q  <= pend_l_d;
    end
  end

  assign addr_out  = addr_p1_q;
  assign in_window = win_p1_q;
  assign pixel_out = pix_p2_q;
  assign off_x     = off_x_q;

endmodule

// File: tb/tb_vga_window_mapper.sv
// Bench for vga_window_mapper: two instances (RAM latency 1 and 2) share
// coordinates and buttons; each reads from its own image RAM model.
module tb_vga_window_mapper;

  localparam int H_RES = 1024, V_RES = 768, CAM_X = 256, SCALE = 1;
  localparam int WIN_W = 512, WIN_H = 512, STEP = 64, MAX_OFF_X = 512;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] posX = '0;
  logic [10:0] posY = '0;
  logic        bntr = 1'b0, bntl = 1'b0;

  logic [2:0]  mem_data1, mem_data2, pix1, pix2;
  logic [15:0] addr1, addr2;
  logic        win1, win2;
  logic [11:0] offx1, offx2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vga_window_mapper #(.RAM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .posX(posX), .posY(posY), .mem_data(mem_data1),
    .bntr(bntr), .bntl(bntl), .addr_out(addr1), .pixel_out(pix1),
    .in_window(win1), .off_x(offx1));

  vga_window_mapper #(.RAM_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .posX(posX), .posY(posY), .mem_data(mem_data2),
    .bntr(bntr), .bntl(bntl), .addr_out(addr2), .pixel_out(pix2),
    .in_window(win2), .off_x(offx2));

  // Image content held in the frame buffer: a cheap function of the address.
  function automatic logic [2:0] img(input logic [15:0] a);
    img = a[2:0] ^ a[10:8] ^ 3'b101;
  endfunction

  // Frame-buffer RAM models with 1 and 2 cycle read latency.
  logic [2:0] rq1 = '0;
  logic [2:0] rq2a = '0, rq2b = '0;
  always @(posedge clk) begin
    rq1  <= img(addr1);
    rq2a <= img(addr2);
    rq2b <= rq2a;
  end
  assign mem_data1 = rq1;
  assign mem_data2 = rq2b;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, req, $time);
    end
  endtask

  // Reference model: window geometry in plain integer arithmetic, histories
  // of window hits for the pixel latency, button levels for edge timing.
  int m_off = 0;
  bit m_pr = 0, m_pl = 0;
  bit hr[3], hl[3];
  bit qw[5];
  int qa[5];
  int e_addr = 0, e_pix1 = 0, e_pix2 = 0;
  bit e_win = 0;
  bit chk_en = 0;

  initial begin
    forever begin
      int x, y, a;
      bit w, rr, rl;
      @(posedge clk);
      x = int'(posX);
      y = int'(posY);
      if (rst) begin
        m_off = 0; m_pr = 0; m_pl = 0;
        for (int k = 0; k < 3; k++) begin hr[k] = 0; hl[k] = 0; end
        for (int k = 0; k < 5; k++) begin qw[k] = 0; qa[k] = 0; end
        e_addr = 0; e_win = 0; e_pix1 = 0; e_pix2 = 0;
        chk_en = 1;
      end else begin
        w = (x >= m_off) && (x < m_off + WIN_W) && (y < WIN_H) &&
            (x < H_RES) && (y < V_RES);
        a = w ? ((y / (1 << SCALE)) * CAM_X + (x - m_off) / (1 << SCALE)) : 0;
        // Pixel after this edge belongs to the sample taken RAM_LAT+2 edges ago.
        e_pix1 = qw[1] ? int'(img(16'(qa[1]))) : 0;
        e_pix2 = qw[2] ? int'(img(16'(qa[2]))) : 0;
        for (int k = 4; k > 0; k--) begin qw[k] = qw[k-1]; qa[k] = qa[k-1]; end
        qw[0] = w; qa[0] = a;
        e_addr = a; e_win = w;
        // A button level becomes a request two cycles after it is sampled.
        rr = hr[1] && !hr[2];
        rl = hl[1] && !hl[2];
        hr[2] = hr[1]; hr[1] = hr[0]; hr[0] = bntr;
        hl[2] = hl[1]; hl[1] = hl[0]; hl[0] = bntl;
        if (y >= V_RES) begin
          if (m_pr && !m_pl)
            m_off = (m_off + STEP > MAX_OFF_X) ? MAX_OFF_X : m_off + STEP;
          else if (m_pl && !m_pr)
            m_off = (m_off < STEP) ? 0 : m_off - STEP;
          m_pr = rr; m_pl = rl;
        end else begin
          m_pr = m_pr | rr; m_pl = m_pl | rl;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("addr1", 32'(addr1), 32'(e_addr));
      check("win1",  32'(win1),  32'(e_win));
      check("pix1",  32'(pix1),  32'(e_pix1));
      check("offx1", 32'(offx1), 32'(m_off));
      check("addr2", 32'(addr2), 32'(e_addr));
      check("win2",  32'(win2),  32'(e_win));
      check("pix2",  32'(pix2),  32'(e_pix2));
      check("offx2", 32'(offx2), 32'(m_off));
    end
  end

  // Drive coordinates, then wait until just after the next active edge.
  task automatic cyc(input int x, input int y);
    posX = 12'(x);
    posY = 11'(y);
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input bit r, input bit l);
    bntr = r; bntl = l;
    repeat (4) cyc(10, 100);
    bntr = 0; bntl = 0;
    repeat (4) cyc(10, 100);
    cyc(10, 768);
    cyc(10, 0);
  endtask

  initial begin
    repeat (3) cyc(0, 0);
    check("rst_addr", 32'(addr1), 0);
    check("rst_win",  32'(win1),  0);
    check("rst_pix",  32'(pix1),  0);
    check("rst_offx", 32'(offx1), 0);
    rst = 0;

    cyc(0, 0);
    check("org_win",  32'(win1),  1);
    check("org_addr", 32'(addr1), 0);
    repeat (2) cyc(0, 0);
    check("org_pix_lat1", 32'(pix1), 5);
    cyc(0, 0);
    check("org_pix_lat2", 32'(pix2), 5);

    cyc(3, 5);
    check("addr_3_5", 32'(addr1), 513);
    cyc(511, 511);
    check("addr_511_511", 32'(addr1), 65535);

    cyc(512, 0);
    check("out_win",  32'(win1),  0);
    check("out_addr", 32'(addr1), 0);
    repeat (2) cyc(512, 0);
    check("out_pix_bg", 32'(pix1), 0);

    // Right request during the visible frame takes effect only in blanking.
    cyc(0, 100);
    bntr = 1;
    repeat (4) cyc(0, 100);
    bntr = 0;
    repeat (6) cyc(0, 100);
    check("hold_offx", 32'(offx1), 0);
    cyc(0, 768);
    check("step_offx", 32'(offx1), 64);
    cyc(0, 0);
    cyc(64, 0);
    check("edge_win",  32'(win1),  1);
    check("edge_addr", 32'(addr1), 0);
    cyc(63, 0);
    check("left_of_win", 32'(win1), 0);

    repeat (10) frame(1, 0);
    check("clamp_max", 32'(offx1), 512);
    repeat (10) frame(0, 1);
    check("clamp_min", 32'(offx1), 0);
    frame(1, 0);
    check("one_step", 32'(offx1), 64);
    frame(1, 1);
    check("both_pend", 32'(offx1), 64);
    frame(0, 0);
    check("pend_cleared", 32'(offx1), 64);
    frame(1, 0);
    check("off_128", 32'(offx1), 128);

    repeat (3) cyc(200, 100);
    rst = 1;
    cyc(200, 100);
    check("mrst_addr", 32'(addr1), 0);
    check("mrst_pix",  32'(pix1),  0);
    check("mrst_win",  32'(win1),  0);
    check("mrst_offx", 32'(offx1), 0);
    rst = 0;

    for (int i = 0; i < 4000; i++) begin
      int x, y;
      x = int'($urandom_range(0, 1100));
      if ($urandom_range(0, 19) == 0) y = int'($urandom_range(768, 805));
      else y = int'($urandom_range(0, 767));
      if ($urandom_range(0, 29) == 0) bntr = ~bntr;
      if ($urandom_range(0, 29) == 0) bntl = ~bntl;
      rst = ($urandom_range(0, 599) == 0);
      cyc(x, y);
    end
    rst = 0;
    cyc(0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
